// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - state encoding and default bus timing for the RTC bus sequencer
// Contents: rtc_state_e (sequencer states), default phase durations, phase timer width.
package rtc_bus_pkg;

    localparam int TIMER_W      = 4;

    localparam int T_SETUP_DEF  = 2;
    localparam int T_STROBE_DEF = 4;
    localparam int T_HOLD_DEF   = 2;
    localparam int T_GAP_DEF    = 2;
    localparam int T_REC_DEF    = 4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_A_SET = 4'd1,
        ST_A_STB = 4'd2,
        ST_A_HLD = 4'd3,
        ST_GAP   = 4'd4,
        ST_D_SET = 4'd5,
        ST_D_STB = 4'd6,
        ST_D_HLD = 4'd7,
        ST_DONE  = 4'd8,
        ST_REC   = 4'd9
    } rtc_state_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter timing every sequencer phase
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   load_i          load load_val_i this cycle (phase entry)
//   load_val_i      phase length minus one
//   zero_o          counter has reached zero; the phase ends on the next edge
module rtc_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed-bus cycle generator (address phase + data phase)
// Optional feature macro: RTC_RECOVERY_EN (adds T_REC idle recovery after DONE).
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   start, rw                transaction request and direction (1 = read), sampled in IDLE
//   busy, done               transaction in progress, one-cycle completion pulse
//   BEnv_Adress, BEnv_Data   register bank drives address / write data onto the bus
//   BRes_Data                register bank captures bus data
//   RTC_CS_n, RTC_AD_n       chip select (active-low), 0 = address phase / 1 = data phase
//   RTC_WR_n, RTC_RD_n       write / read strobes, active-low
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_GAP    = T_GAP_DEF,
    parameter int T_REC    = T_REC_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic rw,
    output logic busy,
    output logic done,
    output logic BEnv_Adress,
    output logic BEnv_Data,
    output logic BRes_Data,
    output logic RTC_CS_n,
    output logic RTC_AD_n,
    output logic RTC_WR_n,
    output logic RTC_RD_n
);

    rtc_state_e         state_q, state_d;
    logic               rw_q, rw_d;
    logic               tmr_zero;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;

    logic busy_q, done_q, bea_q, bed_q, brd_q, cs_q, ad_q, wr_q, rd_q;
    logic busy_d, done_d, bea_d, bed_d, brd_d, cs_d, ad_d, wr_d, rd_d;

    rtc_phase_timer u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next state; each timed phase ends on the edge after the timer reads zero.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_A_SET;
                    rw_d    = rw;
                end
            end
            ST_A_SET: if (tmr_zero) state_d = ST_A_STB;
            ST_A_STB: if (tmr_zero) state_d = ST_A_HLD;
            ST_A_HLD: if (tmr_zero) state_d = ST_GAP;
            ST_GAP:   if (tmr_zero) state_d = ST_D_SET;
            ST_D_SET: if (tmr_zero) state_d = ST_D_STB;
            ST_D_STB: if (tmr_zero) state_d = ST_D_HLD;
            ST_D_HLD: if (tmr_zero) state_d = ST_DONE;
`ifdef RTC_RECOVERY_EN
            ST_DONE:  state_d = ST_REC;
`else
            ST_DONE:  state_d = ST_IDLE;
`endif
            ST_REC:   if (tmr_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Timer is reloaded on every state change with the length of the phase being entered.
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_A_SET, ST_D_SET: tmr_val = TIMER_W'(T_SETUP - 1);
            ST_A_STB, ST_D_STB: tmr_val = TIMER_W'(T_STROBE - 1);
            ST_A_HLD, ST_D_HLD: tmr_val = TIMER_W'(T_HOLD - 1);
            ST_GAP:             tmr_val = TIMER_W'(T_GAP - 1);
            ST_REC:             tmr_val = TIMER_W'(T_REC - 1);
            default:            tmr_val = '0;
        endcase
    end

    // Output decode from the next state so outputs switch on the same edge as the state.
    always_comb begin
        busy_d = 1'b1;
        done_d = 1'b0;
        bea_d  = 1'b0;
        bed_d  = 1'b0;
        brd_d  = 1'b0;
        cs_d   = 1'b1;
        ad_d   = 1'b1;
        wr_d   = 1'b1;
        rd_d   = 1'b1;
        case (state_d)
            ST_IDLE: busy_d = 1'b0;
            ST_A_SET, ST_A_HLD: begin
                cs_d  = 1'b0;
                ad_d  = 1'b0;
                bea_d = 1'b1;
            end
            ST_A_STB: begin
                cs_d  = 1'b0;
                ad_d  = 1'b0;
                bea_d = 1'b1;
                wr_d  = 1'b0;
            end
            ST_D_SET, ST_D_HLD: begin
                cs_d  = 1'b0;
                bed_d = !rw_d;
            end
            ST_D_STB: begin
                cs_d  = 1'b0;
                bed_d = !rw_d;
                wr_d  = rw_d;
                rd_d  = !rw_d;
                brd_d = rw_d;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bea_q   <= 1'b0;
            bed_q   <= 1'b0;
            brd_q   <= 1'b0;
            cs_q    <= 1'b1;
            ad_q    <= 1'b1;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bea_q   <= bea_d;
            bed_q   <= bed_d;
            brd_q   <= brd_d;
            cs_q    <= cs_d;
            ad_q    <= ad_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign BEnv_Adress = bea_q;
    assign BEnv_Data   = bed_q;
    assign BRes_Data   = brd_q;
    assign RTC_CS_n    = cs_q;
    assign RTC_AD_n    = ad_q;
    assign RTC_WR_n    = wr_q;
    assign RTC_RD_n    = rd_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer against a trace model
module tb_rtc_bus_sequencer;

    localparam int TS = 2, TB = 4, TH = 2, TG = 2, TR = 4;
    localparam int LAT = 2 * (TS + TB + TH) + TG + 1;

    logic CLK, RST, start, rw;
    logic busy, done, BEnv_Adress, BEnv_Data, BRes_Data;
    logic RTC_CS_n, RTC_AD_n, RTC_WR_n, RTC_RD_n;

    int n_tests = 0;
    int n_fail  = 0;

    rtc_bus_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .rw          (rw),
        .busy        (busy),
        .done        (done),
        .BEnv_Adress (BEnv_Adress),
        .BEnv_Data   (BEnv_Data),
        .BRes_Data   (BRes_Data),
        .RTC_CS_n    (RTC_CS_n),
        .RTC_AD_n    (RTC_AD_n),
        .RTC_WR_n    (RTC_WR_n),
        .RTC_RD_n    (RTC_RD_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {busy, done, BEnv_Adress, BEnv_Data, BRes_Data, CS_n, AD_n, WR_n, RD_n}
    function automatic logic [8:0] vec(input bit b, d, ba, bd, br, cs, ad, wr, rd);
        return {b, d, ba, bd, br, cs, ad, wr, rd};
    endfunction

    logic [8:0] idle_v;
    logic [8:0] exp_v;
    logic [8:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [8:0] dut_v();
        return {busy, done, BEnv_Adress, BEnv_Data, BRes_Data,
                RTC_CS_n, RTC_AD_n, RTC_WR_n, RTC_RD_n};
    endfunction

    // Expected per-cycle bus trace of one whole transaction, phase by phase.
    task automatic push_n(input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) q.push_back(v);
    endtask

    task automatic build_txn(input bit is_read);
        push_n(vec(1,0,1,0,0,0,0,1,1), TS);
        push_n(vec(1,0,1,0,0,0,0,0,1), TB);
        push_n(vec(1,0,1,0,0,0,0,1,1), TH);
        push_n(vec(1,0,0,0,0,1,1,1,1), TG);
        if (is_read) begin
            push_n(vec(1,0,0,0,0,0,1,1,1), TS);
            push_n(vec(1,0,0,0,1,0,1,1,0), TB);
            push_n(vec(1,0,0,0,0,0,1,1,1), TH);
        end else begin
            push_n(vec(1,0,0,1,0,0,1,1,1), TS);
            push_n(vec(1,0,0,1,0,0,1,0,1), TB);
            push_n(vec(1,0,0,1,0,0,1,1,1), TH);
        end
        push_n(vec(1,1,0,0,0,1,1,1,1), 1);
`ifdef RTC_RECOVERY_EN
        push_n(vec(1,0,0,0,0,1,1,1,1), TR);
`endif
    endtask

    // Advance one clock: update model from inputs seen at the edge, then compare.
    task automatic tick();
        bit s, r;
        s = start;
        r = rw;
        @(posedge CLK);
        if (RST) begin
            q.delete();
            exp_v = idle_v;
        end else begin
            if (!exp_v[8] && s) build_txn(r);
            exp_v = (q.size() != 0) ? q.pop_front() : idle_v;
        end
        #1;
        check("bus_outputs", 32'(dut_v()), 32'(exp_v));
        check("wr_rd_excl", 32'(!(RTC_WR_n == 1'b0 && RTC_RD_n == 1'b0)), 32'd1);
        check("strobe_cs", 32'(!((RTC_WR_n == 1'b0 || RTC_RD_n == 1'b0) && RTC_CS_n)), 32'd1);
        check("ad_data_flags", 32'(!((BEnv_Data || BRes_Data) && !RTC_AD_n)), 32'd1);
    endtask

    int wr_low, rd_low, n_bea, n_bed, n_brd, n_done, done_cyc, cs_hi, min_gap;

    task automatic clear_stats();
        wr_low = 0; rd_low = 0; n_bea = 0; n_bed = 0; n_brd = 0; n_done = 0; done_cyc = -1;
    endtask

    task automatic collect(input int c);
        if (!RTC_WR_n) wr_low++;
        if (!RTC_RD_n) rd_low++;
        if (BEnv_Adress) n_bea++;
        if (BEnv_Data) n_bed++;
        if (BRes_Data) n_brd++;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c + 1;
        end
    endtask

    initial begin
        idle_v = vec(0,0,0,0,0,1,1,1,1);
        exp_v  = idle_v;
        start  = 1'b0;
        rw     = 1'b0;
        RST    = 1'b0;
        #1 RST = 1'b1;
        #1;
        check("reset_state", 32'(dut_v()), 32'(idle_v));
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Write transaction with defaults
        clear_stats();
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            rw    = 1'b0;
            tick();
            collect(c);
        end
        check("wr_wrn_low", wr_low, 2 * TB);
        check("wr_rdn_low", rd_low, 0);
        check("wr_bea", n_bea, TS + TB + TH);
        check("wr_bed", n_bed, TS + TB + TH);
        check("wr_done_cyc", done_cyc, LAT);
        check("wr_done_cnt", n_done, 1);

        // Read transaction; rw toggles after start must be ignored
        clear_stats();
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            rw    = (c == 0) ? 1'b1 : c[0];
            tick();
            collect(c);
        end
        check("rd_rdn_low", rd_low, TB);
        check("rd_brd", n_brd, TB);
        check("rd_bed", n_bed, 0);
        check("rd_wrn_low", wr_low, TB);
        check("rd_done_cyc", done_cyc, LAT);

        // Starts while busy and in the DONE cycle are dropped
        clear_stats();
        for (int c = 0; c < 30; c++) begin
            start = (c == 0 || c == 5 || c == LAT);
            rw    = 1'b0;
            tick();
            collect(c);
        end
        check("busy_start_done_cnt", n_done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("idle_start_accepted", busy, 1'b1);
        for (int c = 0; c < 30; c++) tick();

        // Asynchronous reset in the data strobe phase
        start = 1'b1;
        rw    = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2 * TS + TB + TH + TG; c++) tick();
        check("in_d_stb", 32'({RTC_CS_n, RTC_AD_n, RTC_WR_n}), 32'b010);
        #2 RST = 1'b1;
        #1;
        check("async_rst", 32'(dut_v()), 32'(idle_v));
        q.delete();
        exp_v = idle_v;
        clear_stats();
        for (int c = 0; c < 3; c++) begin
            tick();
            collect(c);
        end
        RST = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            collect(c);
        end
        check("rst_no_done", n_done, 0);

`ifdef RTC_RECOVERY_EN
        // Back-to-back requests: CS_n stays high from DONE through recovery
        min_gap = 1000;
        cs_hi   = -1;
        start   = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done) cs_hi = 0;
            if (cs_hi >= 0) begin
                if (RTC_CS_n) cs_hi++;
                else begin
                    if (cs_hi < min_gap) min_gap = cs_hi;
                    cs_hi = -1;
                end
            end
        end
        start = 1'b0;
        check("rec_cs_gap_ok", 32'(min_gap >= TR + 1 && min_gap < 1000), 32'd1);
        for (int c = 0; c < 30; c++) tick();
`endif

        // Random requests against the model
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 3) == 0);
            rw    = $urandom_range(0, 1) != 0;
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 30; c++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
